// File: rtl/ps2_host_tx_pkg.sv
// Shared state encoding and default timing constants for the PS/2 host transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // 120 us clock inhibit at 100 MHz
  localparam int DEF_INHIBIT_CYC = 12000;
  // data held low this long before the clock line is released
  localparam int DEF_REQ_CYC     = 16;
  // 20 ms maximum gap between device clock falling edges
  localparam int DEF_TIMEOUT_CYC = 2000000;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pad level, plus falling-edge detect.
// Latency: line_s lags the pad by 2 clk; fall asserts 1 cycle when line_s goes 1->0.
// Backpressure: none; free-running.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_s,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronize the pad and keep the previous synced value; idle level is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign line_s = sync;
  assign fall   = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked-out frame, ACK check.
// Latency: INHIBIT_CYC + REQ_CYC cycles of bus preamble, then paced by the device clock.
// Backpressure: tx_ready high only in IDLE; tx_valid while busy is dropped, nothing is queued.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
  parameter int REQ_CYC     = DEF_REQ_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAXC = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;     // inhibit / request phase cycle counter
  logic [3:0]    k_q, k_d;         // device falling edges seen in SEND
  logic [TW-1:0] to_q, to_d;       // cycles since SEND entry or last falling edge
  logic          doe_q, doe_d;     // data drive level presented during SEND
  logic [7:0]    byte_q, byte_d;
  logic          par_q, par_d;

  logic clk_s, clk_fall;
  logic data_s, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_clk_in),
    .line_s  (clk_s),
    .fall    (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_data_in),
    .line_s  (data_s),
    .fall    (data_fall_unused)
  );

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      to_q    <= '0;
      doe_q   <= 1'b0;
      byte_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      to_q    <= to_d;
      doe_q   <= doe_d;
      byte_q  <= byte_d;
      par_q   <= par_d;
    end
  end

  // Next-state, line drive and status pulses; timeout wins over any other event.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    to_d        = to_q;
    doe_d       = doe_q;
    byte_d      = byte_q;
    par_d       = par_q;
    tx_ready    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy     = 1'b0;
        tx_ready = 1'b1;
        if (tx_valid) begin
          byte_d  = tx_data;
          par_d   = ~^tx_data;
          cnt_d   = '0;
          state_d = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q == CW'(INHIBIT_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_REQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        if (cnt_q == CW'(REQ_CYC - 1)) begin
          cnt_d   = '0;
          k_d     = '0;
          to_d    = '0;
          doe_d   = 1'b1;   // start bit stays on the line until the first edge
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_SEND: begin
        ps2_data_oe = doe_q;
        if (to_q == TW'(TIMEOUT_CYC)) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else if (clk_fall) begin
          to_d = '0;
          k_d  = k_q + 4'd1;
          if (k_q < 4'd8) begin
            doe_d = ~byte_q[k_q[2:0]];
          end else if (k_q == 4'd8) begin
            doe_d = ~par_q;
          end else begin
            doe_d   = 1'b0;   // stop bit: release data
            state_d = ST_ACK;
          end
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      ST_ACK: begin
        if (to_q == TW'(TIMEOUT_CYC)) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else if (clk_fall) begin
          to_d = '0;
          if (!data_s) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err     = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      ST_WAIT_IDLE: begin
        if (to_q == TW'(TIMEOUT_CYC)) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else if (clk_s && data_s) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (clk_fall) begin
          to_d = '0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device, random bytes and timing, frame reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int RQ  = 16;
  localparam int TO  = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk, dev_data;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYC (INH),
    .REQ_CYC     (RQ),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_done, n_err, n_clkoe, n_both;
  int n_dual = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample outputs just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done) n_done++;
    if (err) n_err++;
    if (ps2_clk_oe) n_clkoe++;
    if (ps2_clk_oe && ps2_data_oe) n_both++;
    if (done && err) n_dual++;
  endtask

  task automatic clear_stats();
    n_done  = 0;
    n_err   = 0;
    n_clkoe = 0;
    n_both  = 0;
  endtask

  // Reference frame as the device sees it: 8 data bits LSB first, odd parity, stop=1.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    logic p;
    p = (($countones(b) % 2) == 0);
    return {1'b1, p, b};
  endfunction

  task automatic start_tx(input logic [7:0] b);
    int g;
    g = 0;
    while (!tx_ready && g < 100) begin
      tick();
      g++;
    end
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Device side: wait for request-to-send, then clock 11 edges and read bits on rising edges.
  task automatic dev_frame(input logic ack_low, input int abort_edge, input int poke_edge,
                           output logic [9:0] cap, output logic ok);
    int g, lo, hi;
    cap = '0;
    ok  = 1'b1;
    g   = 0;
    while (!(busy && !ps2_clk_oe && ps2_data_oe) && g < 500) begin
      tick();
      g++;
    end
    if (g >= 500) begin
      ok = 1'b0;
      return;
    end
    repeat ($urandom_range(5, 15)) tick();
    for (int e = 1; e <= 11; e++) begin
      lo = $urandom_range(8, 20);
      hi = $urandom_range(8, 20);
      if (e == 11) begin
        dev_data = !ack_low;
        repeat (3) tick();
      end
      dev_clk = 1'b0;
      if (e == abort_edge) begin
        repeat (lo) tick();
        return;
      end
      if (e == poke_edge) begin
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        tick();
        tx_valid = 1'b0;
        lo--;
      end
      repeat (lo) tick();
      dev_clk = 1'b1;
      if (e <= 10) cap[e-1] = ps2_data_in;
      repeat (hi) tick();
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!tx_ready && g < 300) begin
      tick();
      g++;
    end
    chk("ready_after_frame", {31'd0, tx_ready}, 32'd1);
  endtask

  // One full transfer with frame, preamble timing and completion status checked.
  task automatic run_frame(input logic [7:0] b, input logic ack_low, input int poke,
                           output logic [9:0] cap);
    logic ok;
    clear_stats();
    start_tx(b);
    dev_frame(ack_low, 0, poke, cap, ok);
    chk("device_saw_rts", {31'd0, ok}, 32'd1);
    wait_ready();
    chk("frame_bits", {22'd0, cap}, {22'd0, ref_frame(b)});
    chk("clk_inhibit_cycles", n_clkoe, INH + RQ);
    chk("data_low_in_inhibit", n_both, RQ);
    chk("done_count", n_done, ack_low ? 1 : 0);
    chk("err_count", n_err, ack_low ? 0 : 1);
    chk("idle_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
  endtask

  initial begin
    logic [9:0] cap;
    logic       ok;
    int         t0, g, busy_seen;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Known command bytes, also checked against hand-derived frames.
    run_frame(8'hED, 1'b1, 0, cap);
    chk("frame_ED_const", {22'd0, cap}, 32'h3ED);
    run_frame(8'hF4, 1'b1, 0, cap);
    chk("frame_F4_const", {22'd0, cap}, 32'h2F4);

    // Random bytes with random device clock timing.
    for (int i = 0; i < 4; i++) begin
      run_frame(8'($urandom), 1'b1, 0, cap);
      repeat ($urandom_range(2, 10)) tick();
    end

    // Device leaves data high at edge 11: missing ACK.
    run_frame(8'($urandom), 1'b0, 0, cap);
    chk("nack_busy", {31'd0, busy}, 32'd0);

    // Device never clocks: timeout measured from first SEND cycle.
    clear_stats();
    start_tx(8'h5A);
    g = 0;
    while (!(busy && !ps2_clk_oe) && g < 200) begin
      tick();
      g++;
    end
    t0 = cyc;
    g  = 0;
    while (!err && g < 1500) begin
      tick();
      g++;
    end
    chk("timeout_cycles", cyc - t0, TO);
    chk("timeout_done", n_done, 0);
    tick();
    chk("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("timeout_ready", {31'd0, tx_ready}, 32'd1);

    // Reset after edge 5 drops the bus immediately.
    clear_stats();
    start_tx(8'hED);
    dev_frame(1'b1, 6, 0, cap, ok);
    rst = 1'b1;
    #1;
    chk("midrst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("midrst_ready", {31'd0, tx_ready}, 32'd1);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    run_frame(8'hED, 1'b1, 0, cap);

    // New request mid-frame is dropped, original byte goes out intact.
    run_frame(8'($urandom_range(1, 255)), 1'b1, 3, cap);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) busy_seen++;
    end
    chk("no_queued_frame", busy_seen, 0);

    chk("done_err_same_cycle", n_dual, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYC, default 12000, clock-inhibit duration in clk cycles (120 us at 100 MHz).
REQ-002 Parameter REQ_CYC, default 16, cycles data is held low before clock release.
REQ-003 Parameter TIMEOUT_CYC, default 2000000, maximum clk cycles between device clock falling edges (20 ms).
REQ-004 clk  in  1  system clock, 100 MHz.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 tx_data  in  8  command byte to send to the keyboard.
REQ-007 tx_valid  in  1  request; accepted only while tx_ready=1.
REQ-008 tx_ready  out  1  high in IDLE only.
REQ-009 busy  out  1  high whenever state is not IDLE; the receiver ignores the lines while busy.
REQ-010 done  out  1  one-cycle pulse: frame acknowledged and bus idle.
REQ-011 err  out  1  one-cycle pulse: missing ACK or timeout.
REQ-012 ps2_clk_in, ps2_data_in  in  1 each  raw pad levels.
REQ-013 ps2_clk_oe, ps2_data_oe  out  1 each  1 drives the line low; 0 releases it (open-drain, pulled high).

Function
REQ-014 States: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-015 ps2_clk_in and ps2_data_in pass through a 2-flop synchronizer; a clock falling edge is synced-previous=1 and synced-current=0.
REQ-016 IDLE with tx_valid=1: latch tx_data; compute parity = ~^tx_data (odd); next cycle INHIBIT, tx_ready=0.
REQ-017 INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYC cycles, then REQ.
REQ-018 REQ: clk_oe=1, data_oe=1 (start bit) for REQ_CYC cycles, then SEND with clk_oe=0.
REQ-019 SEND: 4-bit edge counter k. Falling edges 1-8 present data bit k-1, LSB first. Edge 9 presents parity. Edge 10 releases data (stop bit = 1). Then go to ACK.
REQ-020 Presented bit b: data_oe = ~b, updated the cycle after the detected edge and held until the next edge.
REQ-021 ACK: on falling edge 11, sample synced data. 0: go to WAIT_IDLE. 1: pulse err, go to IDLE.
REQ-022 WAIT_IDLE: once synced clk and data are both 1, pulse done and go to IDLE.
REQ-023 Timeout counter clears on entry to SEND and at every falling edge. In SEND, ACK or WAIT_IDLE, reaching TIMEOUT_CYC pulses err and returns to IDLE.
REQ-024 Whenever state is IDLE, both oe outputs are 0.
REQ-025 tx_valid while busy is ignored; no queuing.
REQ-026 done and err are never asserted in the same cycle.

Reset
REQ-027 On rst: state=IDLE, tx_ready=1, busy=0, done=0, err=0, clk_oe=0, data_oe=0, and all counters and synchronizers cleared (synchronizers to 1); takes effect immediately, including mid-frame.

Structure
REQ-028 Shared package holds the state encoding and the default INHIBIT_CYC, REQ_CYC and TIMEOUT_CYC constants.
REQ-029 One sub-module, ps2_line_sync (2-flop synchronizer plus falling-edge detect), instantiated for clk and data.

Verification (INHIBIT_CYC=50, REQ_CYC=16, TIMEOUT_CYC=1000)
REQ-030 Send 0xED, device model clocks 11 edges, ACK low: clk_oe high exactly 66 cycles, data low for the final 16 of them. Captured bits are 1,0,1,1,0,1,1,1, parity 1, stop 1. One done pulse, then tx_ready=1.
REQ-031 Send 0xF4: bits 0,0,1,0,1,1,1,1, parity 0, done pulse.
REQ-032 Data held high at edge 11: err pulse, no done, IDLE, both oe=0.
REQ-033 Device never clocks: err pulse exactly 1000 cycles after entering SEND, lines released.
REQ-034 rst asserted after edge 5: oe outputs 0 immediately, tx_ready=1; a new 0xED transfer afterwards completes normally.
REQ-035 tx_valid pulsed mid-frame with 0x00: ignored; the original byte completes unchanged.
